cluster_clock_gating_ctrl: RTL and testbench

Multi-channel, idle-driven clock-gate controller for the cluster clock tree. It replaces hand-driven per-unit enables: each channel gates its own clock after a programmable number of idle cycles. A channel re-enables its clock through a request/acknowledge wake handshake with a fixed settling time. The block sits between the cluster clock root and NB_CH peripheral or core clock domains, and keeps a glitch-free latch-based gate per channel.

---
 rtl/cluster_clock_gating_ctrl.sv | 129 ++++++++++++
 tb/tb_cluster_clock_gating_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_clock_gating_ctrl.sv
// Idle-driven per-channel clock gating with a request/acknowledge wake handshake.
// Define CLUSTER_CG_STATS_EN to build the per-channel gated-cycle statistics counters.
module cluster_clock_gating_ctrl #(
  parameter int unsigned NB_CH       = 4,
  parameter int unsigned IDLE_W      = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned STAT_W      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    test_en_i,
  input  logic [IDLE_W-1:0]       idle_thresh_i,
  input  logic [NB_CH-1:0]        force_on_i,
  input  logic [NB_CH-1:0]        req_i,
  output logic [NB_CH-1:0]        ack_o,
  output logic [NB_CH-1:0]        gated_o,
  output logic [NB_CH-1:0]        clk_o,
  input  logic                    stat_clr_i,
  output logic [NB_CH*STAT_W-1:0] stat_o
);

  typedef enum logic [1:0] {RUN, COUNT, GATED, WAKE} state_t;

  localparam logic [3:0]      WAKE_LAST = (WAKE_CYCLES == 0) ? 4'd0 : 4'(WAKE_CYCLES - 1);
  localparam logic [IDLE_W:0] CNT_ONE   = (IDLE_W+1)'(1);

  state_t            state_q [NB_CH];
  state_t            state_d [NB_CH];
  logic [IDLE_W-1:0] cnt_q   [NB_CH];
  logic [IDLE_W-1:0] cnt_d   [NB_CH];
  logic [3:0]        wcnt_q  [NB_CH];
  logic [3:0]        wcnt_d  [NB_CH];
  logic [NB_CH-1:0]  en_q;
  logic [NB_CH-1:0]  en_d;
  logic [NB_CH-1:0]  r;
  logic              thresh_on;

  assign r         = req_i | force_on_i;
  assign thresh_on = (idle_thresh_i != '0);

  always_comb begin
    for (int unsigned c = 0; c < NB_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      wcnt_d[c]  = wcnt_q[c];
      unique case (state_q[c])
        RUN: begin
          if (!r[c] && thresh_on) begin
            state_d[c] = COUNT;
            cnt_d[c]   = '0;
          end
        end
        COUNT: begin
          // cnt+1 >= T rather than equality, so lowering T mid-count gates at once
          if (r[c] || !thresh_on) begin
            state_d[c] = RUN;
            cnt_d[c]   = '0;
          end else if (({1'b0, cnt_q[c]} + CNT_ONE) >= {1'b0, idle_thresh_i}) begin
            state_d[c] = GATED;
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end
        GATED: begin
          if (r[c]) begin
            state_d[c] = (WAKE_CYCLES == 0) ? RUN : WAKE;
            wcnt_d[c]  = '0;
          end
        end
        WAKE: begin
          if (wcnt_q[c] == WAKE_LAST) state_d[c] = RUN;
          else                        wcnt_d[c]  = wcnt_q[c] + 1'b1;
        end
        default: state_d[c] = RUN;
      endcase
      en_d[c]    = (state_d[c] != GATED);
      ack_o[c]   = req_i[c] & ((state_q[c] == RUN) | (state_q[c] == COUNT)) & ~rst_i;
      gated_o[c] = (state_q[c] == GATED);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NB_CH; c++) begin
      if (rst_i) begin
        state_q[c] <= RUN;
        cnt_q[c]   <= '0;
        wcnt_q[c]  <= '0;
        en_q[c]    <= 1'b1;
      end else begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        wcnt_q[c]  <= wcnt_d[c];
        en_q[c]    <= en_d[c];
      end
    end
  end

  // Enable comes straight from a flop and is only sampled while clk_i is low
  for (genvar c = 0; c < NB_CH; c++) begin : g_gate
    logic latch_q;
    always_latch begin
      if (!clk_i) latch_q <= en_q[c] | test_en_i;
    end
    assign clk_o[c] = clk_i & latch_q;
  end

`ifdef CLUSTER_CG_STATS_EN
  logic [STAT_W-1:0] stat_q [NB_CH];

  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NB_CH; c++) begin
      if (rst_i || stat_clr_i) begin
        stat_q[c] <= '0;
      end else if ((state_q[c] == GATED) && (stat_q[c] != '1)) begin
        stat_q[c] <= stat_q[c] + STAT_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NB_CH; c++) begin : g_stat
    assign stat_o[c*STAT_W +: STAT_W] = stat_q[c];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_o          = '0;
`endif

endmodule

// File: tb/tb_cluster_clock_gating_ctrl.sv
// Scoreboard bench for cluster_clock_gating_ctrl: expected values queued at stimulus time,
// popped and compared once the DUT responds. Stat expectations follow CLUSTER_CG_STATS_EN.
module tb_cluster_clock_gating_ctrl;
  localparam int unsigned NB_CH       = 4;
  localparam int unsigned IDLE_W      = 8;
  localparam int unsigned WAKE_CYCLES = 2;
  localparam int unsigned STAT_W      = 32;
`ifdef CLUSTER_CG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                    clk_i = 1'b0;
  logic                    rst_i, test_en_i, stat_clr_i;
  logic [IDLE_W-1:0]       idle_thresh_i;
  logic [NB_CH-1:0]        force_on_i, req_i, ack_o, gated_o, clk_o;
  logic [NB_CH*STAT_W-1:0] stat_o;

  cluster_clock_gating_ctrl #(
    .NB_CH(NB_CH), .IDLE_W(IDLE_W), .WAKE_CYCLES(WAKE_CYCLES), .STAT_W(STAT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_en_i(test_en_i), .idle_thresh_i(idle_thresh_i),
    .force_on_i(force_on_i), .req_i(req_i), .ack_o(ack_o), .gated_o(gated_o),
    .clk_o(clk_o), .stat_clr_i(stat_clr_i), .stat_o(stat_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_clko0 = 0, n_clko1 = 0, n_clko2 = 0, n_clko3 = 0;
  always @(posedge clk_o[0]) n_clko0++;
  always @(posedge clk_o[1]) n_clko1++;
  always @(posedge clk_o[2]) n_clko2++;
  always @(posedge clk_o[3]) n_clko3++;

  function automatic int unsigned clko_count(input int c);
    case (c)
      0:       return n_clko0;
      1:       return n_clko1;
      2:       return n_clko2;
      default: return n_clko3;
    endcase
  endfunction

  int unsigned  vectors = 0, miscompares = 0;
  logic [63:0]  exp_q [$];
  string        name_q [$];
  logic [63:0]  obs, exv;
  string        nm;

  task automatic push(input string n, input logic [63:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; test_en_i = 1'b0; stat_clr_i = 1'b0;
    idle_thresh_i = 8'd4; force_on_i = '0; req_i = '1;
    push("reset_ack_gated", 64'h0);
    push("reset_stat_zero", 64'h0);
    tick(); tick();
    obs = {56'd0, ack_o, gated_o};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    obs = {63'd0, |stat_o};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    rst_i = 1'b0;
    push("post_reset_ack", {56'd0, 4'hF, 4'h0});
    tick();
    obs = {56'd0, ack_o, gated_o};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
  endtask

  // ch0 idles with T=4: gated after edge k+4, last clk_o edge at k+4
  task automatic test_gate();
    int unsigned p;
    req_i[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push($sformatf("gate_e%0d", i), {59'd0, 3'b000, 1'(i >= 4), 1'(i <= 4)});
      p = clko_count(0);
      tick();
      obs = {59'd0, gated_o, 1'(clko_count(0) - p)};
      exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
      if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    end
  endtask

  // ch0 woken: clk_o from w+1, ack after w+2; 4 GATED edges counted
  task automatic test_wake();
    int unsigned p;
    req_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("wake_e%0d", i), {61'd0, 1'b0, 1'(i >= 2), 1'(i >= 1)});
      p = clko_count(0);
      tick();
      obs = {61'd0, gated_o[0], ack_o[0], 1'(clko_count(0) - p)};
      exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
      if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    end
    push("wake_stat", STATS ? 64'd4 : 64'd0);
    obs = {32'd0, stat_o[0 +: STAT_W]};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
  endtask

  // ch1 request returns on the edge where cnt==T-1: request wins
  task automatic test_race();
    int unsigned p;
    idle_thresh_i = 8'd4;
    for (int i = 0; i < 10; i++) begin
      req_i[1] = (i >= 4);
      push($sformatf("race_e%0d", i), {61'd0, 1'b0, 1'(i >= 4), 1'b1});
      p = clko_count(1);
      tick();
      obs = {61'd0, gated_o[1], ack_o[1], 1'(clko_count(1) - p)};
      exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
      if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    end
  endtask

  // lowering T below the running count gates at the very next edge
  task automatic test_thresh_lower();
    idle_thresh_i = 8'd200;
    req_i[1] = 1'b0;
    push("lower_before", 64'd0);
    push("lower_after", 64'd1);
    repeat (10) tick();
    obs = {63'd0, gated_o[1]};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    idle_thresh_i = 8'd3;
    tick();
    obs = {63'd0, gated_o[1]};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    req_i[1] = 1'b1;
    repeat (3) tick();
    idle_thresh_i = 8'd4;
  endtask

  // ch2: T=0 and force_on both block gating; force_on wakes a gated channel
  task automatic test_force_on();
    int unsigned p;
    idle_thresh_i = 8'd0;
    req_i[2] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 9) push($sformatf("t0_e%0d", i), 64'd0);
      tick();
      if (i % 10 == 9) begin
        obs = {63'd0, gated_o[2]};
        exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
        if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
      end
    end
    idle_thresh_i = 8'd4;
    force_on_i[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i % 10 == 9) push($sformatf("force_e%0d", i), 64'd0);
      tick();
      if (i % 10 == 9) begin
        obs = {63'd0, gated_o[2]};
        exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
        if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
      end
    end
    force_on_i[2] = 1'b0;
    push("force_gated", 64'd1);
    repeat (6) tick();
    obs = {63'd0, gated_o[2]};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    force_on_i[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_i[2] = (i >= 1);
      push($sformatf("force_wake_e%0d", i), {61'd0, 1'b0, 1'(i >= 2), 1'(i >= 1)});
      p = clko_count(2);
      tick();
      obs = {61'd0, gated_o[2], ack_o[2], 1'(clko_count(2) - p)};
      exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
      if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    end
    force_on_i[2] = 1'b0;
  endtask

  // ch3: test_en opens the gate without touching the FSM; reset aborts a wake
  task automatic test_test_en_reset();
    int unsigned p;
    req_i[3] = 1'b0;
    push("ch3_gated", 64'd1);
    repeat (6) tick();
    obs = {63'd0, gated_o[3]};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    test_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("test_en_e%0d", i), 64'd3);
      p = clko_count(3);
      tick();
      obs = {62'd0, gated_o[3], 1'(clko_count(3) - p)};
      exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
      if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    end
    test_en_i = 1'b0;
    req_i[3] = 1'b1;
    push("mid_wake", 64'd0);
    tick();
    obs = {62'd0, gated_o[3], ack_o[3]};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    rst_i = 1'b1;
    push("rst_mid_wake", 64'd0);
    tick();
    obs = {55'd0, ack_o, gated_o, |stat_o};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    rst_i = 1'b0;
    push("rst_release_ack", {56'd0, 4'hF, 4'h0});
    #1;
    obs = {56'd0, ack_o, gated_o};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
  endtask

  // clear beats a same-edge increment, then counting resumes from 1
  task automatic test_stat_clr();
    idle_thresh_i = 8'd4;
    req_i[0] = 1'b0;
    push("stat_pre_clr", STATS ? 64'd3 : 64'd0);
    repeat (8) tick();
    obs = {32'd0, stat_o[0 +: STAT_W]};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    stat_clr_i = 1'b1;
    push("stat_clr_edge", 64'd0);
    tick();
    stat_clr_i = 1'b0;
    obs = {32'd0, stat_o[0 +: STAT_W]};
    exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
    if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    for (int i = 1; i <= 2; i++) begin
      push($sformatf("stat_resume_%0d", i), STATS ? 64'(i) : 64'd0);
      tick();
      obs = {32'd0, stat_o[0 +: STAT_W]};
      exv = exp_q.pop_front(); nm = name_q.pop_front(); vectors++;
      if (obs !== exv) begin miscompares++; $display("FAIL %s: got %0h expected %0h", nm, obs, exv); end
    end
    req_i[0] = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_gate();
    test_wake();
    test_race();
    test_thresh_lower();
    test_force_on();
    test_test_en_reset();
    test_stat_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
